// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port address (MSB first), length (MSB first),
// then payload (LSB first), each bit paced by the shared clkEn strobe.
module serial_frame_tx #(
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned LEN_W  = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clkEn,
   input  logic                        start,
   input  logic [ADDR_W-1:0]           port_sel,
   input  logic [LEN_W-1:0]            len,
   input  logic [(1 << LEN_W)-2:0]     data_in,
   output logic                        ser_out,
   output logic                        ready,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned DATA_W = (1 << LEN_W) - 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_LEN   = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]        state;
   logic              pending;
   logic [ADDR_W-1:0] port_sh;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  len_sh;
   logic [DATA_W-1:0] data_sh;
   logic [1:0]        fcnt;
   logic [LEN_W-1:0]  dcnt;
   logic              accept;

   assign ready  = (state == S_IDLE) && !pending;
   assign busy   = pending || (state == S_START) || (state == S_ADDR) ||
                   (state == S_LEN) || (state == S_DATA);
   assign done   = (state == S_DONE);
   assign accept = start && ready;

   // ser_out always carries the bit of the current state; each branch loads the
   // first bit of the next field on the clkEn edge that leaves the previous one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         pending <= 1'b0;
         port_sh <= '0;
         len_q   <= '0;
         len_sh  <= '0;
         data_sh <= '0;
         fcnt    <= '0;
         dcnt    <= '0;
         ser_out <= 1'b1;
      end else begin
         if (accept) begin
            pending <= 1'b1;
            port_sh <= port_sel;
            len_q   <= len;
            len_sh  <= len;
            data_sh <= data_in;
         end
         case (state)
            S_IDLE: begin
               if (clkEn && pending) begin
                  state   <= S_START;
                  pending <= 1'b0;
                  ser_out <= 1'b0;
               end
            end
            S_START: begin
               if (clkEn) begin
                  state   <= S_ADDR;
                  ser_out <= port_sh[ADDR_W-1];
                  port_sh <= port_sh << 1;
                  fcnt    <= 2'(ADDR_W - 1);
               end
            end
            S_ADDR: begin
               if (clkEn) begin
                  if (fcnt == 2'd0) begin
                     state   <= S_LEN;
                     ser_out <= len_sh[LEN_W-1];
                     len_sh  <= len_sh << 1;
                     fcnt    <= 2'(LEN_W - 1);
                  end else begin
                     ser_out <= port_sh[ADDR_W-1];
                     port_sh <= port_sh << 1;
                     fcnt    <= fcnt - 2'd1;
                  end
               end
            end
            S_LEN: begin
               if (clkEn) begin
                  if (fcnt != 2'd0) begin
                     ser_out <= len_sh[LEN_W-1];
                     len_sh  <= len_sh << 1;
                     fcnt    <= fcnt - 2'd1;
                  end else if (len_q != '0) begin
                     state   <= S_DATA;
                     ser_out <= data_sh[0];
                     data_sh <= data_sh >> 1;
                     dcnt    <= len_q;
                  end else begin
                     state   <= S_DONE;
                     ser_out <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (clkEn) begin
                  // dcnt counts payload bits still owed, including the one on the line
                  if (dcnt == LEN_W'(1)) begin
                     state   <= S_DONE;
                     ser_out <= 1'b1;
                     dcnt    <= '0;
                  end else begin
                     ser_out <= data_sh[0];
                     data_sh <= data_sh >> 1;
                     dcnt    <= dcnt - LEN_W'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state   <= S_IDLE;
               ser_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a behavioural line receiver decodes ser_out and
// checks each frame against a queue of frames pushed when start was driven.
module tb_serial_frame_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        clkEn;
   logic        start;
   logic [1:0]  port_sel;
   logic [3:0]  len;
   logic [14:0] data_in;
   logic        ser_out;
   logic        ready;
   logic        busy;
   logic        done;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic [1:0]  p;
      logic [3:0]  l;
      logic [14:0] d;
   } frame_t;
   frame_t exp_q[$];

   serial_frame_tx #(.ADDR_W(2), .LEN_W(4)) dut (
      .clk(clk), .rst(rst), .clkEn(clkEn), .start(start),
      .port_sel(port_sel), .len(len), .data_in(data_in),
      .ser_out(ser_out), .ready(ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // clkEn strobe: high one clock in every en_div
   int unsigned en_div = 1;
   int unsigned en_ph  = 0;
   initial begin
      clkEn = 1'b0;
      forever begin
         @(negedge clk);
         clkEn = ((en_ph % en_div) == 0);
         en_ph++;
      end
   end

   logic en_edge = 1'b0;
   always @(posedge clk) en_edge <= clkEn;

   // receiver model
   int          rx_st = 0;
   int          rx_k  = 0;
   logic [1:0]  rport;
   logic [3:0]  rlen;
   logic [14:0] rdata;
   bit          await_done = 0;
   logic        prev_ser;
   bit          prev_ok = 0;
   logic [31:0] cur_bits, last_bits;
   int          cur_n = 0, last_n = 0;
   int          frames_rx = 0;

   task automatic complete();
      frame_t      e;
      logic [14:0] m;
      rx_st      = 0;
      await_done = 1;
      last_bits  = cur_bits;
      last_n     = cur_n;
      frames_rx++;
      if (exp_q.size() == 0) begin
         chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         m = '0;
         for (int i = 0; i < int'(e.l); i++) m[i] = 1'b1;
         chk("rx_port", 32'(rport), 32'(e.p));
         chk("rx_len", 32'(rlen), 32'(e.l));
         chk("rx_data", 32'(rdata), 32'(e.d & m));
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            rx_st      = 0;
            await_done = 0;
            prev_ok    = 0;
            exp_q.delete();
            chk("rst_done", 32'(done), 32'd0);
         end else begin
            chk("done", 32'(done), 32'(await_done && en_edge));
            if (await_done && en_edge) begin
               chk("done_busy", 32'(busy), 32'd0);
               await_done = 0;
            end
            if (!en_edge && prev_ok) chk("hold", 32'(ser_out), 32'(prev_ser));
            if (en_edge) begin
               if (rx_st == 0) begin
                  if (ser_out == 1'b0) begin
                     rx_st = 1; rx_k = 0; rport = '0; rlen = '0; rdata = '0;
                     cur_bits = 32'd0; cur_n = 1;
                  end
               end else begin
                  cur_bits = {cur_bits[30:0], ser_out};
                  cur_n++;
                  case (rx_st)
                     1: begin
                        rport = {rport[0], ser_out};
                        rx_k++;
                        if (rx_k == 2) begin rx_st = 2; rx_k = 0; end
                     end
                     2: begin
                        rlen = {rlen[2:0], ser_out};
                        rx_k++;
                        if (rx_k == 4) begin
                           if (rlen == 4'd0) complete();
                           else begin rx_st = 3; rx_k = 0; end
                        end
                     end
                     default: begin
                        rdata[rx_k] = ser_out;
                        rx_k++;
                        if (rx_k == int'(rlen)) complete();
                     end
                  endcase
               end
            end
            prev_ser = ser_out;
            prev_ok  = 1;
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!ready && t < 500) begin @(negedge clk); t++; end
      chk("ready_wait", 32'(ready), 32'd1);
   endtask

   task automatic send(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d);
      frame_t f;
      wait_ready();
      f.p = p; f.l = l; f.d = d;
      exp_q.push_back(f);
      start = 1'b1; port_sel = p; len = l; data_in = d;
      @(negedge clk);
      start = 1'b0;
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_ready", 32'(ready), 32'd0);
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || !ready) && t < 2000) begin @(negedge clk); t++; end
      chk("drain_queue", 32'(exp_q.size()), 32'd0);
      chk("drain_ready", 32'(ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_bits;
      int          f0, t;
      rst = 1'b0; start = 1'b0; port_sel = '0; len = '0; data_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_ser", 32'(ser_out), 32'd1);
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      #2 rst = 1'b1;

      // clkEn every clock, port 2, len 3, data 5
      en_div = 1;
      send(2'b10, 4'd3, 15'h0005);
      drain();
      chk("t2_nbits", 32'(last_n), 32'd10);
      exp_bits = 32'b0100011101;
      chk("t2_bits", last_bits, exp_bits);

      // zero-length payload
      send(2'b01, 4'd0, 15'h7FFF);
      drain();
      chk("t3_nbits", 32'(last_n), 32'd7);
      exp_bits = 32'b0010000;
      chk("t3_bits", last_bits, exp_bits);

      // maximum payload with slow strobe; inputs scrambled mid-frame
      en_div = 4;
      send(2'b11, 4'd15, 15'h7FFF);
      repeat (20) @(negedge clk);
      port_sel = 2'b00; len = 4'd2; data_in = 15'h1234;
      drain();
      chk("t4_nbits", 32'(last_n), 32'd22);
      exp_bits = {10'd0, 1'b0, 2'b11, 4'hF, 15'h7FFF};
      chk("t4_bits", last_bits, exp_bits);

      // start while busy is ignored
      en_div = 2;
      f0 = frames_rx;
      send(2'b00, 4'd2, 15'h0003);
      start = 1'b1; port_sel = 2'b11; len = 4'd9; data_in = 15'h5555;
      repeat (4) @(negedge clk);
      chk("t5_ready_busy", 32'(ready), 32'd0);
      start = 1'b0;
      drain();
      repeat (20) @(negedge clk);
      chk("t5_one_frame", 32'(frames_rx - f0), 32'd1);
      send(2'b11, 4'd9, 15'h01A5);
      drain();
      chk("t5_retry", 32'(frames_rx - f0), 32'd2);

      // receiver-style frame: port 3, len 5, data 10110
      en_div = 3;
      send(2'b11, 4'd5, 15'b10110);
      drain();
      chk("t6_nbits", 32'(last_n), 32'd12);
      exp_bits = 32'b011_0101_01101;
      chk("t6_bits", last_bits, exp_bits);

      // asynchronous reset in the middle of the payload
      en_div = 1;
      send(2'b00, 4'd15, 15'h0000);
      t = 0;
      while (rx_st != 3 && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      chk("t1_in_data", 32'(ser_out), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("t1_ser", 32'(ser_out), 32'd1);
      chk("t1_ready", 32'(ready), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      f0 = frames_rx;
      repeat (30) @(negedge clk);
      chk("t1_no_frame", 32'(frames_rx - f0), 32'd0);
      send(2'b01, 4'd1, 15'h0001);
      drain();
      chk("t1_recover", 32'(frames_rx - f0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
